// File: rtl/perf_event_monitor_if.sv
// Control, event and readout bundle between the CPU-side logic and perf_event_monitor.
// The CPU-side logic drives the master side and the monitor is the slave.
interface perf_event_monitor_if #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter int SEL_W   = 4
);
  logic               start_i;
  logic               clear_i;
  logic [NUM_EVT-1:0] evt_i;
  logic [NUM_EVT-1:0] evt_mask_i;
  logic [SEL_W-1:0]   rd_sel_i;
  logic [CNT_W-1:0]   rd_data_o;
  logic [CNT_W-1:0]   cycle_o;
  logic               running_o;
  logic               done_o;
  logic [NUM_EVT:0]   sat_o;

  modport master (
    output start_i, clear_i, evt_i, evt_mask_i, rd_sel_i,
    input  rd_data_o, cycle_o, running_o, done_o, sat_o
  );

  modport slave (
    input  start_i, clear_i, evt_i, evt_mask_i, rd_sel_i,
    output rd_data_o, cycle_o, running_o, done_o, sat_o
  );
endinterface

// File: rtl/perf_event_monitor.sv
// Pipeline performance monitor: it counts run cycles and masked events with saturating
// counters, stops itself after CYCLE_LIMIT run cycles, and has a registered readout mux.
module perf_event_monitor #(
  parameter int NUM_EVT     = 4,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 30,
  parameter int SEL_W       = 4
) (
  input logic                 clk_i,
  input logic                 rst_i,
  perf_event_monitor_if.slave mon
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(CYCLE_LIMIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NUM_EVT+1];
  logic [CNT_W-1:0] cnt_d [NUM_EVT+1];
  logic [NUM_EVT:0] sat_q, sat_d;
  logic [NUM_EVT:0] inc;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  // Slot 0 is the cycle counter and slot k+1 is event channel k.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves a value unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    inc       = '0;
    rd_data_d = '0;

    for (int i = 0; i <= NUM_EVT; i++) begin
      if (int'(mon.rd_sel_i) == i) rd_data_d = cnt_q[i];
    end

    if (mon.clear_i) begin
      for (int i = 0; i <= NUM_EVT; i++) cnt_d[i] = '0;
      sat_d   = '0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (mon.start_i) state_d = RUN;
        RUN: begin
          inc = {mon.evt_i & mon.evt_mask_i, 1'b1};
          for (int i = 0; i <= NUM_EVT; i++) begin
            if (inc[i]) begin
              if (cnt_q[i] == CNT_MAX) sat_d[i] = 1'b1;
              else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          // Reaching the budget wins over a simultaneous pause.
          if (CYCLE_LIMIT != 0 && cnt_d[0] == LIMIT) state_d = DONE;
          else if (!mon.start_i)                     state_d = IDLE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the counters are a small set of flops rather than a RAM, so each one gets a reset value.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '{default: '0};
      sat_q     <= '0;
      rd_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign mon.rd_data_o = rd_data_q;
  assign mon.cycle_o   = cnt_q[0];
  assign mon.running_o = (state_q == RUN);
  assign mon.done_o    = (state_q == DONE);
  assign mon.sat_o     = sat_q;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Randomised and directed bench for perf_event_monitor. Two instances (32-bit with a
// 30-cycle budget, and 4-bit unlimited) are checked every cycle against a count-based model.
`timescale 1ns/100ps
module tb_perf_event_monitor;

  localparam int NUM_EVT = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, clear = 1'b0;
  logic [3:0] evt = '0, mask = '0, sel = '0;

  int n_total = 0;
  int n_bad   = 0;

  // Model state: unbounded event tallies; a counter reads min(tally, max) and is saturated when tally > max.
  longint m_cnt [2][NUM_EVT+1];
  int     m_state [2];
  longint m_rd [2];

  perf_event_monitor_if #(.NUM_EVT(NUM_EVT), .CNT_W(32), .SEL_W(4)) if_a ();
  perf_event_monitor_if #(.NUM_EVT(NUM_EVT), .CNT_W(4),  .SEL_W(4)) if_b ();

  assign if_a.start_i = start;  assign if_b.start_i = start;
  assign if_a.clear_i = clear;  assign if_b.clear_i = clear;
  assign if_a.evt_i = evt;      assign if_b.evt_i = evt;
  assign if_a.evt_mask_i = mask; assign if_b.evt_mask_i = mask;
  assign if_a.rd_sel_i = sel;   assign if_b.rd_sel_i = sel;

  perf_event_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(32), .CYCLE_LIMIT(30), .SEL_W(4)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .mon(if_a.slave));
  perf_event_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(4), .CYCLE_LIMIT(0), .SEL_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .mon(if_b.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint max_of(input int d);
    return (d == 0) ? 64'hFFFF_FFFF : 64'd15;
  endfunction

  function automatic longint shown(input int d, input int k);
    return (m_cnt[d][k] > max_of(d)) ? max_of(d) : m_cnt[d][k];
  endfunction

  function automatic logic [4:0] sat_exp(input int d);
    logic [4:0] s;
    for (int k = 0; k <= NUM_EVT; k++) s[k] = (m_cnt[d][k] > max_of(d));
    return s;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k <= NUM_EVT; k++) m_cnt[d][k] = 0;
      m_state[d] = M_IDLE;
      m_rd[d]    = 0;
    end
  endtask

  // One clock edge of the monitor's rules, applied to the inputs held before the edge.
  task automatic model_step(input int d);
    int limit;
    limit = (d == 0) ? 30 : 0;
    m_rd[d] = (int'(sel) <= NUM_EVT) ? shown(d, int'(sel)) : 0;
    if (clear) begin
      for (int k = 0; k <= NUM_EVT; k++) m_cnt[d][k] = 0;
      m_state[d] = M_IDLE;
    end else if (m_state[d] == M_RUN) begin
      m_cnt[d][0]++;
      for (int k = 0; k < NUM_EVT; k++) if (evt[k] && mask[k]) m_cnt[d][k+1]++;
      if (limit != 0 && m_cnt[d][0] == limit) m_state[d] = M_DONE;
      else if (!start)                       m_state[d] = M_IDLE;
    end else if (m_state[d] == M_IDLE && start) begin
      m_state[d] = M_RUN;
    end
  endtask

  task automatic compare_all();
    check("a_running", if_a.running_o, m_state[0] == M_RUN);
    check("a_done",    if_a.done_o,    m_state[0] == M_DONE);
    check("a_cycle",   if_a.cycle_o,   shown(0, 0));
    check("a_rd_data", if_a.rd_data_o, m_rd[0]);
    check("a_sat",     if_a.sat_o,     sat_exp(0));
    check("b_running", if_b.running_o, m_state[1] == M_RUN);
    check("b_done",    if_b.done_o,    m_state[1] == M_DONE);
    check("b_cycle",   if_b.cycle_o,   shown(1, 0));
    check("b_rd_data", if_b.rd_data_o, m_rd[1]);
    check("b_sat",     if_b.sat_o,     sat_exp(1));
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step();
    clear = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check("rst_rd_data", if_a.rd_data_o, 0);
    check("rst_cycle",   if_a.cycle_o,   0);
    check("rst_sat",     if_b.sat_o,     0);
    check("rst_flags",   {if_a.running_o, if_a.done_o, if_b.running_o, if_b.done_o}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Budget: 30 run cycles then DONE, held for 10 more cycles with start still high.
    start = 1'b1; mask = 4'b1111; evt = 4'b0101;
    steps(41);
    check("limit_done",  if_a.done_o,  1);
    check("limit_cycle", if_a.cycle_o, 30);

    // Masking: channel 1 disabled while both channels fire.
    pulse_clear();
    mask = 4'b0001; evt = 4'b0000; step();
    evt = 4'b0011; steps(5);
    evt = 4'b0000; start = 1'b0; step();
    sel = 4'd1; step(); check("mask_sel1", if_a.rd_data_o, 5);
    sel = 4'd2; step(); check("mask_sel2", if_a.rd_data_o, 0);

    // Saturation of the 4-bit instance, then clear.
    pulse_clear();
    mask = 4'b1111; evt = 4'b0100; start = 1'b1; step();
    steps(20);
    evt = 4'b0000; start = 1'b0; step();
    sel = 4'd3; step();
    check("sat_read", if_b.rd_data_o, 15);
    check("sat_flag", if_b.sat_o[3], 1);
    pulse_clear(); step();
    check("clr_read", if_b.rd_data_o, 0);
    check("clr_sat",  if_b.sat_o,     0);

    // Pause mid-run, then resume.
    sel = 4'd0; evt = 4'b0001; start = 1'b1; steps(5);
    start = 1'b0; steps(3);
    check("pause_running", if_a.running_o, 0);
    start = 1'b1; steps(5);

    // Clear wins over a same-cycle event.
    evt = 4'b0001; clear = 1'b1; step(); clear = 1'b0;
    check("clr_evt_cycle", if_a.cycle_o,   0);
    check("clr_evt_run",   if_a.running_o, 0);

    // Randomised stretch.
    for (int i = 0; i < 400; i++) begin
      start = ($urandom % 8) != 0;
      clear = ($urandom % 50) == 0;
      evt   = 4'($urandom);
      mask  = 4'($urandom);
      sel   = 4'($urandom);
      step();
    end
    clear = 1'b0;

    // Asynchronous reset mid-run, away from any edge.
    pulse_clear();
    start = 1'b1; evt = 4'b1111; mask = 4'b1111; sel = 4'd1; steps(6);
    #2 rst_n = 1'b0;
    #0.5;
    model_reset();
    check("arst_a_cycle", if_a.cycle_o, 0);
    check("arst_a_rd",    if_a.rd_data_o, 0);
    check("arst_a_flags", {if_a.running_o, if_a.done_o, if_a.sat_o}, 0);
    check("arst_b_cycle", if_b.cycle_o, 0);
    check("arst_b_flags", {if_b.running_o, if_b.done_o, if_b.sat_o}, 0);
    #0.5 rst_n = 1'b1;

    // Out-of-range select reads zero.
    steps(5);
    sel = 4'd9; step();
    check("sel9_a", if_a.rd_data_o, 0);
    check("sel9_b", if_b.rd_data_o, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
